// File: rtl/fetch_queue_ctrl.sv
// Instruction prefetch sequencer: fills a circular byte queue from the memory bus
// and presents the three oldest bytes (with their PC) to the decoder.
module fetch_queue_ctrl #(
  parameter int          DEPTH    = 16,
  parameter int          PTR_W    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [15:0]      redirect_pc,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  output logic [7:0]       q_byte0,
  output logic [7:0]       q_byte1,
  output logic [7:0]       q_byte2,
  output logic [PTR_W:0]   q_count,
  output logic [15:0]      q_pc,
  input  logic             dec_take,
  input  logic [1:0]       dec_len,
  output logic             flush_busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t           state, state_nx;
  logic [7:0]       queue [DEPTH];
  logic [PTR_W-1:0] ptr_s, ptr_e;
  logic [PTR_W:0]   count, next_count, take_len;
  logic [15:0]      fetch_addr, pc, pending_pc;
  logic             push, take_ok, can_fetch;
  logic [PTR_W-1:0] idx1, idx2;

  // A redirect cancels both push and take in its cycle; DRAIN never moves the queue.
  assign take_ok    = dec_take && (dec_len != 2'd0) && ({{(PTR_W-1){1'b0}}, dec_len} <= count)
                      && (state != DRAIN) && !redirect_valid;
  assign push       = mem_ack && (state == FETCH) && !redirect_valid;
  assign take_len   = take_ok ? {{(PTR_W-1){1'b0}}, dec_len} : '0;
  assign next_count = count + {{PTR_W{1'b0}}, push} - take_len;
  assign can_fetch  = fetch_en && (next_count < FULL);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (redirect_valid) state_nx = fetch_en ? FETCH : IDLE;
        else if (can_fetch) state_nx = FETCH;
      end
      FETCH: begin
        if (redirect_valid) state_nx = mem_ack ? (fetch_en ? FETCH : IDLE) : DRAIN;
        else if (mem_ack)   state_nx = can_fetch ? FETCH : IDLE;
      end
      DRAIN: begin
        if (mem_ack) state_nx = fetch_en ? FETCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      flush_busy <= 1'b0;
      ptr_s      <= '0;
      ptr_e      <= '0;
      count      <= '0;
      fetch_addr <= RESET_PC;
      pc         <= RESET_PC;
      pending_pc <= 16'h0000;
    end else begin
      state      <= state_nx;
      mem_req    <= (state_nx == FETCH) || (state_nx == DRAIN);
      flush_busy <= (state_nx == DRAIN);
      if (redirect_valid) begin
        ptr_s <= '0;
        ptr_e <= '0;
        count <= '0;
        pc    <= redirect_pc;
        if (state == DRAIN) begin
          pending_pc <= redirect_pc;
          if (mem_ack) fetch_addr <= redirect_pc;
        end else if (state == FETCH && !mem_ack) begin
          pending_pc <= redirect_pc;
        end else begin
          fetch_addr <= redirect_pc;
        end
      end else begin
        count <= next_count;
        if (take_ok) begin
          ptr_s <= ptr_s + take_len[PTR_W-1:0];
          pc    <= pc + {14'd0, dec_len};
        end
        if (push) begin
          ptr_e      <= ptr_e + PTR_W'(1);
          fetch_addr <= fetch_addr + 16'd1;
        end
        if (state == DRAIN && mem_ack) fetch_addr <= pending_pc;
      end
    end
  end

  // Byte storage carries no reset; reads are masked by count.
  always_ff @(posedge clk) begin
    if (push) queue[ptr_e] <= mem_rdata;
  end

  assign idx1 = ptr_s + PTR_W'(1);
  assign idx2 = ptr_s + PTR_W'(2);

  assign q_byte0  = (count > (PTR_W+1)'(0)) ? queue[ptr_s] : 8'h00;
  assign q_byte1  = (count > (PTR_W+1)'(1)) ? queue[idx1]  : 8'h00;
  assign q_byte2  = (count > (PTR_W+1)'(2)) ? queue[idx2]  : 8'h00;
  assign q_count  = count;
  assign q_pc     = pc;
  assign mem_addr = fetch_addr;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Scoreboard bench for fetch_queue_ctrl: expected request addresses and queued
// bytes are queued as stimulus is driven and compared as the DUT produces them.
module tb_fetch_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  q_byte0, q_byte1, q_byte2;
  logic [4:0]  q_count;
  logic [15:0] q_pc;
  logic        dec_take;
  logic [1:0]  dec_len;
  logic        flush_busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  sb[$];
  logic [15:0] exp_addr[$];
  logic        ack_mode = 1'b0;

  always #5 clk = ~clk;

  fetch_queue_ctrl #(.DEPTH(16), .PTR_W(4), .RESET_PC(16'h0200)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .q_byte0(q_byte0), .q_byte1(q_byte1), .q_byte2(q_byte2),
    .q_count(q_count), .q_pc(q_pc),
    .dec_take(dec_take), .dec_len(dec_len), .flush_busy(flush_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    logic [7:0] e, g;
    chk($sformatf("%s_cnt", tag), q_count, sb.size());
    for (int i = 0; i < 3; i++) begin
      e = (i < sb.size()) ? sb[i] : 8'h00;
      g = (i == 0) ? q_byte0 : (i == 1) ? q_byte1 : q_byte2;
      chk($sformatf("%s_b%0d", tag, i), g, e);
    end
  endtask

  // One clock: bus responder acks if enabled, scoreboard tracks what the queue should hold.
  task automatic cycle();
    int len;
    mem_ack   = ack_mode && mem_req;
    mem_rdata = mem_addr[7:0];
    if (mem_ack) begin
      chk("addr_q_nonempty", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) chk("mem_addr", mem_addr, exp_addr.pop_front());
    end
    len = int'(dec_len);
    if (redirect_valid) sb.delete();
    else if (!flush_busy) begin
      if (dec_take && len >= 1 && len <= sb.size())
        repeat (len) void'(sb.pop_front());
      if (mem_ack) sb.push_back(mem_rdata);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; dec_take = 1'b0; dec_len = 2'd0; redirect_valid = 1'b0;
  endtask

  task automatic take(input logic [1:0] len);
    dec_take = 1'b1; dec_len = len;
    cycle();
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    mem_ack = 1'b0; mem_rdata = 8'h0; dec_take = 1'b0; dec_len = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", q_count, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_flush", flush_busy, 0);
    chk("rst_pc", q_pc, 16'h0200);
    chk("rst_addr", mem_addr, 16'h0200);
    chk("rst_b0", q_byte0, 8'h00);
    rst = 1'b0;

    // Fill from reset
    fetch_en = 1'b1; ack_mode = 1'b1;
    for (int a = 0; a < 16; a++) exp_addr.push_back(16'h0200 + 16'(a));
    for (int i = 0; i < 40 && q_count != 5'd16; i++) cycle();
    chk("fill_count", q_count, 16);
    chk("fill_req", mem_req, 0);
    chk("fill_pc", q_pc, 16'h0200);
    chk("fill_b2", q_byte2, 8'h02);
    chk("fill_addr_left", exp_addr.size(), 0);
    check_bytes("fill");
    cycle();
    chk("full_no_req", mem_req, 0);

    // Retire and refill
    ack_mode = 1'b0;
    take(2'd3);
    chk("take_cnt", q_count, 13);
    chk("take_pc", q_pc, 16'h0203);
    chk("take_b0", q_byte0, 8'h03);
    chk("take_req", mem_req, 1);
    chk("take_addr", mem_addr, 16'h0210);
    check_bytes("take");
    take(2'd3); take(2'd3); take(2'd2);
    chk("pre_pt_cnt", q_count, 5);
    chk("pre_pt_pc", q_pc, 16'h020B);

    // Simultaneous push and take
    exp_addr.push_back(16'h0210);
    ack_mode = 1'b1;
    take(2'd2);
    ack_mode = 1'b0;
    chk("pt_cnt", q_count, 4);
    chk("pt_pc", q_pc, 16'h020D);
    chk("pt_addr", mem_addr, 16'h0211);
    chk("pt_b0", q_byte0, 8'h0D);
    check_bytes("pt");

    // Redirect with the request outstanding, then a second redirect while draining
    redirect_valid = 1'b1; redirect_pc = 16'h7000;
    cycle();
    chk("rd_cnt", q_count, 0);
    chk("rd_pc", q_pc, 16'h7000);
    chk("rd_flush", flush_busy, 1);
    chk("rd_req", mem_req, 1);
    chk("rd_addr", mem_addr, 16'h0211);
    chk("rd_b0", q_byte0, 8'h00);
    cycle();
    redirect_valid = 1'b1; redirect_pc = 16'h8000;
    cycle();
    chk("rd2_pc", q_pc, 16'h8000);
    chk("rd2_flush", flush_busy, 1);
    chk("rd2_addr", mem_addr, 16'h0211);
    exp_addr.push_back(16'h0211);
    ack_mode = 1'b1;
    cycle();
    ack_mode = 1'b0;
    chk("drain_flush", flush_busy, 0);
    chk("drain_addr", mem_addr, 16'h8000);
    chk("drain_req", mem_req, 1);
    chk("drain_cnt", q_count, 0);

    // Redirect coinciding with an ack, then fetch across the 16-bit wrap
    exp_addr.push_back(16'h8000);
    ack_mode = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    cycle();
    chk("rda_addr", mem_addr, 16'hFFFE);
    chk("rda_pc", q_pc, 16'hFFFE);
    chk("rda_cnt", q_count, 0);
    chk("rda_flush", flush_busy, 0);
    exp_addr.push_back(16'hFFFE); exp_addr.push_back(16'hFFFF);
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
    for (int i = 0; i < 4; i++) begin
      fetch_en = (i < 3);
      cycle();
    end
    ack_mode = 1'b0;
    chk("wrap_cnt", q_count, 4);
    chk("wrap_req", mem_req, 0);
    chk("wrap_b0", q_byte0, 8'hFE);
    chk("wrap_b1", q_byte1, 8'hFF);
    chk("wrap_b2", q_byte2, 8'h00);
    chk("wrap_addr_left", exp_addr.size(), 0);
    take(2'd3);
    chk("wrap_take_pc", q_pc, 16'h0001);
    chk("wrap_take_cnt", q_count, 1);
    chk("wrap_take_b0", q_byte0, 8'h01);
    chk("wrap_take_b1", q_byte1, 8'h00);

    // Illegal takes
    take(2'd2);
    chk("ill2_cnt", q_count, 1);
    chk("ill2_pc", q_pc, 16'h0001);
    chk("ill2_b0", q_byte0, 8'h01);
    take(2'd0);
    chk("ill0_cnt", q_count, 1);
    chk("ill0_pc", q_pc, 16'h0001);
    check_bytes("ill0");
    take(2'd1);
    chk("empty_cnt", q_count, 0);
    chk("empty_pc", q_pc, 16'h0002);
    chk("empty_b0", q_byte0, 8'h00);

    // Reset while a request is outstanding
    fetch_en = 1'b1;
    cycle();
    chk("pre_rst_req", mem_req, 1);
    chk("pre_rst_addr", mem_addr, 16'h0002);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_pc", q_pc, 16'h0200);
    chk("mid_rst_addr", mem_addr, 16'h0200);
    chk("mid_rst_flush", flush_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
